pe_conv1d_mf: RTL and testbench
===============================

// Module: pe_conv1d_mf
// PURPOSE
//  Next-generation 1-D convolution processing element for the ECG CNN accelerator.
//  Holds a K-sample sliding window of signed N-bit activations and M filters of K weights.
//  Emits one M-channel dot-product per accepted sample once the window is full.
//  Uses valid/ready streaming with back-pressure; xout forwards samples so PEs can be chained.
// PARAMETERS
//  N          8         activation/weight width, signed two's complement
//  K          7         taps per filter (window depth), K>=2
//  M          2         filters (output channels) computed in parallel
//  SUM_WIDTH  2*N+4     per-channel accumulator width; must satisfy >= 2*N+$clog2(K)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            synchronous, active-low reset
//  clear      in   1            sync flush of window, fill count and pipeline; weights kept
//  w_load     in   1            latch win into weight registers this cycle
//  win        in   M*K*N        packed weights; filter m, tap k at [(m*K+k)*N +: N]
//  in_valid   in   1            xin valid
//  in_ready   out  1            PE can accept xin
//  xin        in   N            input activation
//  out_valid  out  1            sum valid
//  out_ready  in   1            downstream accepts sum
//  sum        out  M*SUM_WIDTH  channel m at [m*SUM_WIDTH +: SUM_WIDTH]
//  xout       out  N            registered copy of last accepted xin
//  xout_valid out  1            one-cycle pulse, one cycle after each accept
// BEHAVIOUR
//  Reset (rst=0 at edge): window, fill count, weights, sum, xout cleared to 0;
//   out_valid=0, xout_valid=0. in_ready=0 while rst=0.
//  Handshake: stall = out_valid & ~out_ready; in_ready = ~stall & ~clear & rst.
//   Accept = in_valid & in_ready. sum/out_valid held stable while stall.
//  Window: on accept, shift; tap k multiplies x[t-k] (k=0 newest sample).
//  Fill counter 0..K, saturates at K; result generated only for accepts where count
//   reaches/is K (i.e. the K-th accept and every accept after).
//  Pipeline, 2 stages, frozen as a whole during stall:
//   S1: M*K products (2*N bits, signed) registered, with window-full tag.
//   S2: per-channel adder tree, sign-extended to SUM_WIDTH, registered into sum.
//   Latency: accept at edge t -> out_valid high after edge t+2 (if no stall).
//   Throughput 1 result/cycle with out_ready=1.
//  No overflow by construction given SUM_WIDTH rule; no rounding, no truncation.
//  Weights: w_load any cycle; new weights apply to samples accepted after that edge;
//   products already in S1/S2 keep old weights. w_load during stall still loads.
//  clear: next edge window, count, S1 tag, out_valid zeroed; sum value retained;
//   clear with in_valid -> sample dropped (in_ready already 0). clear beats accept.
//  Reset mid-stream: all in-flight results discarded, no out_valid afterwards until
//   K new accepts.
//  xout/xout_valid not affected by stall beyond accept gating.
// CONFIGURATION
//  PE_RELU_EN defined: S2 applies ReLU per channel; negative sums output as 0.
//  PE_RELU_EN undefined: raw signed sums output. Latency identical in both builds.
// TESTING (N=8,K=7,M=2; f0 all taps +1, f1 taps k even +1 / k odd -1)
//  Feed 1..7, out_ready=1 -> single out_valid 2 cycles after 7th accept; sum0=28, sum1=4.
//  Continue with 8 -> next cycle sum0=35, sum1=5; no out_valid for first 6 accepts.
//  All x=-128, all w=-128 -> sum0=sum1=114688; no wrap in 20 bits.
//  out_ready=0 for 3 cycles with out_valid high -> sum held, in_ready=0, no sample lost.
//  Feed -1..-7 with f0: sum0=-28 without PE_RELU_EN; 0 with PE_RELU_EN.
//  clear (or rst=0) after 4 accepts -> 7 fresh accepts required before next out_valid.

Source files
------------

// File: rtl/pe_conv1d_mf_if.sv
// Streaming interface for pe_conv1d_mf: sample input, result output, forward.
// Modports: master (upstream/downstream side), slave (the PE itself).
interface pe_conv1d_mf_if #(
    parameter int N         = 8,
    parameter int M         = 2,
    parameter int SUM_WIDTH = 2*N+4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N-1:0]           xin;
    logic                   out_valid;
    logic                   out_ready;
    logic [M*SUM_WIDTH-1:0] sum;
    logic [N-1:0]           xout;
    logic                   xout_valid;

    modport master (
        output in_valid, xin, out_ready,
        input  in_ready, out_valid, sum, xout, xout_valid
    );

    modport slave (
        input  in_valid, xin, out_ready,
        output in_ready, out_valid, sum, xout, xout_valid
    );
endinterface

// File: rtl/pe_conv1d_mf.sv
// 1-D convolution PE: K-tap window, M filters, 2-stage MAC pipeline.
// Ports: clk, rst (sync active-low), clear, w_load, win, bus (slave modport).
// Build option: define PE_RELU_EN to clamp negative channel sums to zero.
module pe_conv1d_mf #(
    parameter int N         = 8,
    parameter int K         = 7,
    parameter int M         = 2,
    parameter int SUM_WIDTH = 2*N+4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             w_load,
    input  logic [M*K*N-1:0] win,
    pe_conv1d_mf_if.slave    bus
);
    localparam int CW = $clog2(K+1);

    if (SUM_WIDTH < 2*N + $clog2(K)) begin : g_bad_width
        $error("SUM_WIDTH too small for N and K");
    end
    if (K < 2) begin : g_bad_k
        $error("K must be at least 2");
    end

    logic signed [N-1:0]         r_win  [K];
    logic signed [N-1:0]         r_w    [M][K];
    // Weights snapshot paired with the sample waiting in the window, so
    // a load on the accept edge never reaches that sample.
    logic signed [N-1:0]         r_wp   [M][K];
    logic signed [2*N-1:0]       r_prod [M][K];
    logic signed [SUM_WIDTH-1:0] r_sum  [M];
    logic [CW-1:0]               r_cnt;
    logic                        r_t0;
    logic                        r_s1_v;
    logic                        r_out_valid;
    logic [N-1:0]                r_xout;
    logic                        r_xout_valid;

    logic                        w_stall;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_full;
    logic signed [2*N-1:0]       w_prod [M][K];
    logic signed [SUM_WIDTH-1:0] w_acc  [M];
    logic signed [SUM_WIDTH-1:0] w_s2   [M];
    logic [M*SUM_WIDTH-1:0]      w_sum_pk;

    assign w_stall    = r_out_valid & ~bus.out_ready;
    assign w_in_ready = ~w_stall & ~clear & rst;
    assign w_accept   = bus.in_valid & w_in_ready;
    // This accept is the K-th (or later) one.
    assign w_full     = (r_cnt >= CW'(K-1));

    always_comb begin
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                w_prod[m][k] = (2*N)'(r_wp[m][k]) * (2*N)'(r_win[k]);
            end
        end
    end

    always_comb begin
        for (int m = 0; m < M; m++) begin
            w_acc[m] = '0;
            for (int k = 0; k < K; k++) begin
                w_acc[m] = w_acc[m] + SUM_WIDTH'(r_prod[m][k]);
            end
`ifdef PE_RELU_EN
            w_s2[m] = w_acc[m][SUM_WIDTH-1] ? '0 : w_acc[m];
`else
            w_s2[m] = w_acc[m];
`endif
        end
    end

    always_comb begin
        w_sum_pk = '0;
        for (int m = 0; m < M; m++) begin
            w_sum_pk[m*SUM_WIDTH +: SUM_WIDTH] = r_sum[m];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < K; k++) begin
                r_win[k] <= '0;
            end
            for (int m = 0; m < M; m++) begin
                for (int k = 0; k < K; k++) begin
                    r_w[m][k]    <= '0;
                    r_wp[m][k]   <= '0;
                    r_prod[m][k] <= '0;
                end
                r_sum[m] <= '0;
            end
            r_cnt        <= '0;
            r_t0         <= 1'b0;
            r_s1_v       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_xout       <= '0;
            r_xout_valid <= 1'b0;
        end else begin
            if (w_load) begin
                for (int m = 0; m < M; m++) begin
                    for (int k = 0; k < K; k++) begin
                        r_w[m][k] <= win[(m*K+k)*N +: N];
                    end
                end
            end

            r_xout_valid <= w_accept;
            if (w_accept) begin
                r_xout <= bus.xin;
            end

            if (clear) begin
                for (int k = 0; k < K; k++) begin
                    r_win[k] <= '0;
                end
                r_cnt       <= '0;
                r_t0        <= 1'b0;
                r_s1_v      <= 1'b0;
                r_out_valid <= 1'b0;
            end else if (!w_stall) begin
                if (w_accept) begin
                    r_win[0] <= bus.xin;
                    for (int k = 1; k < K; k++) begin
                        r_win[k] <= r_win[k-1];
                    end
                    if (r_cnt != CW'(K)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                r_t0 <= w_accept & w_full;
                for (int m = 0; m < M; m++) begin
                    for (int k = 0; k < K; k++) begin
                        r_wp[m][k]   <= r_w[m][k];
                        r_prod[m][k] <= w_prod[m][k];
                    end
                    r_sum[m] <= w_s2[m];
                end
                r_s1_v      <= r_t0;
                r_out_valid <= r_s1_v;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.sum        = w_sum_pk;
    assign bus.xout       = r_xout;
    assign bus.xout_valid = r_xout_valid;
endmodule

// File: tb/tb_pe_conv1d_mf.sv
// Directed bench for pe_conv1d_mf (N=8, K=7, M=2, SUM_WIDTH=20).
// Drives on the falling edge, observes on the falling edge.
module tb_pe_conv1d_mf;
    localparam int N  = 8;
    localparam int K  = 7;
    localparam int M  = 2;
    localparam int SW = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             w_load;
    logic [M*K*N-1:0] win;
    int               nvec = 0;
    int               nerr = 0;

    pe_conv1d_mf_if #(.N(N), .M(M), .SUM_WIDTH(SW)) bus ();

    pe_conv1d_mf #(.N(N), .K(K), .M(M), .SUM_WIDTH(SW)) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .w_load (w_load),
        .win    (win),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // mode 0: f0 all +1, f1 +1 on even taps / -1 on odd; mode 1: all -128
    task automatic set_w(input int mode);
        logic [N-1:0] v;
        for (int m = 0; m < M; m++) begin
            for (int k = 0; k < K; k++) begin
                if (mode == 1)
                    v = 8'h80;
                else if (m == 1 && (k % 2) == 1)
                    v = 8'hFF;
                else
                    v = 8'h01;
                win[(m*K+k)*N +: N] = v;
            end
        end
        w_load = 1'b1;
        @(negedge clk);
        w_load = 1'b0;
    endtask

    task automatic feed(input int x);
        bus.in_valid = 1'b1;
        bus.xin      = N'(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_out(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nvec++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rst_in_ready: got %b want 0", bus.in_ready);
        end
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.xout_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_valids: got %b%b want 00",
                     bus.out_valid, bus.xout_valid);
        end
        nvec++;
        if (bus.sum !== '0 || bus.xout !== '0) begin
            nerr++;
            $display("FAIL rst_data: got sum=%h xout=%h want 0",
                     bus.sum, bus.xout);
        end
        rst = 1'b1;
        #1;
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rel_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    // 1..8 back to back; results after the 7th and 8th accepts
    task automatic test_fill();
        int  s0, s1;
        logic ev;
        set_w(0);
        bus.in_valid = 1'b1;
        bus.xin      = 8'd1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            s0 = $signed(bus.sum[SW-1:0]);
            s1 = $signed(bus.sum[2*SW-1:SW]);
            ev = (c == 9 || c == 10);
            nvec++;
            if (bus.out_valid !== ev) begin
                nerr++;
                $display("FAIL fill_valid c%0d: got %b want %b",
                         c, bus.out_valid, ev);
            end
            if (c == 9) begin
                nvec++;
                if (s0 !== 28 || s1 !== 4) begin
                    nerr++;
                    $display("FAIL fill_sum7: got %0d,%0d want 28,4",
                             s0, s1);
                end
            end
            if (c == 10) begin
                nvec++;
                if (s0 !== 35 || s1 !== 5) begin
                    nerr++;
                    $display("FAIL fill_sum8: got %0d,%0d want 35,5",
                             s0, s1);
                end
            end
            if (c == 1 || c == 8) begin
                nvec++;
                if (bus.xout !== N'(c) || bus.xout_valid !== 1'b1) begin
                    nerr++;
                    $display("FAIL xout c%0d: got %0d/%b want %0d/1",
                             c, bus.xout, bus.xout_valid, c);
                end
            end
            if (c < 8)
                bus.xin = N'(c + 1);
            else
                bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        bit got;
        int s0, s1;
        do_clear();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) feed(i);
        wait_out(got);
        nvec++;
        if (!got) begin
            nerr++;
            $display("FAIL stall_timeout: got no out_valid want 1");
        end
        bus.in_valid = 1'b1;
        bus.xin      = 8'd8;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s0 = $signed(bus.sum[SW-1:0]);
            nvec++;
            if (bus.out_valid !== 1'b1 || s0 !== 28
                || bus.in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stall_hold c%0d: got v%b s%0d r%b want v1 s28 r0",
                         c, bus.out_valid, s0, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        nvec++;
        if (bus.out_valid !== 1'b0 || bus.xout !== 8'd8) begin
            nerr++;
            $display("FAIL stall_release: got v%b x%0d want v0 x8",
                     bus.out_valid, bus.xout);
        end
        wait_out(got);
        s0 = $signed(bus.sum[SW-1:0]);
        s1 = $signed(bus.sum[2*SW-1:SW]);
        nvec++;
        if (!got || s0 !== 35 || s1 !== 5) begin
            nerr++;
            $display("FAIL stall_next: got %b %0d,%0d want 1 35,5",
                     got, s0, s1);
        end
    endtask

    task automatic test_clear();
        bit got;
        int s0, s1;
        do_clear();
        for (int i = 0; i < 4; i++) feed(100);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.xin      = 8'd50;
        #1;
        nvec++;
        if (bus.in_ready !== 1'b0) begin
            nerr++;
            $display("FAIL clr_in_ready: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 6; i++) feed(i);
        for (int c = 0; c < 4; c++) begin
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL clr_early c%0d: got %b want 0",
                         c, bus.out_valid);
            end
            @(negedge clk);
        end
        feed(7);
        wait_out(got);
        s0 = $signed(bus.sum[SW-1:0]);
        s1 = $signed(bus.sum[2*SW-1:SW]);
        nvec++;
        if (!got || s0 !== 28 || s1 !== 4) begin
            nerr++;
            $display("FAIL clr_sum: got %b %0d,%0d want 1 28,4",
                     got, s0, s1);
        end
    endtask

    task automatic test_negative();
        bit got;
        int s0, s1, e0, e1;
`ifdef PE_RELU_EN
        e0 = 0;
        e1 = 0;
`else
        e0 = -28;
        e1 = -4;
`endif
        do_clear();
        for (int i = 1; i <= 7; i++) feed(-i);
        wait_out(got);
        s0 = $signed(bus.sum[SW-1:0]);
        s1 = $signed(bus.sum[2*SW-1:SW]);
        nvec++;
        if (!got || s0 !== e0 || s1 !== e1) begin
            nerr++;
            $display("FAIL neg_sum: got %b %0d,%0d want 1 %0d,%0d",
                     got, s0, s1, e0, e1);
        end
    endtask

    task automatic test_extreme();
        bit got;
        int s0, s1;
        do_clear();
        set_w(1);
        for (int i = 0; i < 7; i++) feed(-128);
        wait_out(got);
        s0 = $signed(bus.sum[SW-1:0]);
        s1 = $signed(bus.sum[2*SW-1:SW]);
        nvec++;
        if (!got || s0 !== 114688 || s1 !== 114688) begin
            nerr++;
            $display("FAIL extreme: got %b %0d,%0d want 1 114688,114688",
                     got, s0, s1);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int s0, s1;
        do_clear();
        set_w(0);
        for (int i = 1; i <= 7; i++) feed(i);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        nvec++;
        if (bus.sum !== '0) begin
            nerr++;
            $display("FAIL rmid_sum: got %h want 0", bus.sum);
        end
        for (int c = 0; c < 4; c++) begin
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rmid_flush c%0d: got %b want 0",
                         c, bus.out_valid);
            end
            @(negedge clk);
        end
        set_w(0);
        for (int i = 0; i < 4; i++) feed(9);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        set_w(0);
        for (int i = 1; i <= 6; i++) feed(i);
        for (int c = 0; c < 3; c++) begin
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL rmid_early c%0d: got %b want 0",
                         c, bus.out_valid);
            end
            @(negedge clk);
        end
        feed(7);
        wait_out(got);
        s0 = $signed(bus.sum[SW-1:0]);
        s1 = $signed(bus.sum[2*SW-1:SW]);
        nvec++;
        if (!got || s0 !== 28 || s1 !== 4) begin
            nerr++;
            $display("FAIL rmid_sum2: got %b %0d,%0d want 1 28,4",
                     got, s0, s1);
        end
    endtask

    initial begin
        rst           = 1'b0;
        clear         = 1'b0;
        w_load        = 1'b0;
        win           = '0;
        bus.in_valid  = 1'b0;
        bus.xin       = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_fill();
        test_stall();
        test_clear();
        test_negative();
        test_extreme();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
